// File: rtl/fourier_pkg.sv
// Shared definitions for the inverse DFT core: fixed-point defaults, op codes, FSM states, saturation.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fourier_pkg;

  localparam int     FRAC_DEF  = 16;
  localparam longint SCALE_DEF = 64'sd1 <<< FRAC_DEF;
  localparam real    PI        = 3.14159265358979323846;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WR    = 2'b01,
    OP_START = 2'b10,
    OP_RD    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_STORE = 2'd2
  } state_e;

  // Clamp v to the signed range of a w-bit word; caller truncates the result to w bits.
  function automatic logic signed [127:0] sat(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle table: returns cos/sin(2*pi*idx/N) in Q(FRAC) fixed point from a single cosine table.
// Latency: combinational.
// Backpressure: none; pure lookup.
//   idx  : twiddle index, already reduced mod N
//   w_re : cos(2*pi*idx/N) * 2**FRAC
//   w_im : sin(2*pi*idx/N) * 2**FRAC
module twiddle_rom
  import fourier_pkg::*;
#(
  parameter int N    = 16,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic [$clog2(N)-1:0] idx,
  output logic signed [W-1:0]  w_re,
  output logic signed [W-1:0]  w_im
);

  localparam int LG = $clog2(N);

  // Round to nearest, symmetric about zero, so cos(pi/2) lands exactly on 0.
  function automatic logic signed [W-1:0] to_fix(input real r);
    real s;
    s = r * (2.0 ** FRAC);
    if (s >= 0.0) return W'($rtoi(s + 0.5));
    else          return -W'($rtoi(-s + 0.5));
  endfunction

  logic signed [W-1:0] cos_tab [N];

  for (genvar k = 0; k < N; k++) begin : g_tab
    assign cos_tab[k] = to_fix($cos(2.0 * PI * k / N));
  end

  assign w_re = cos_tab[idx];

  // sin(theta) = cos(theta - pi/2): quarter-period shift of the same table.
  // With N=2 every angle is a multiple of pi, so the sine is identically zero.
  if (N >= 4) begin : g_sin
    logic [LG-1:0] sin_idx;
    assign sin_idx = idx - LG'(N / 4);
    assign w_im    = cos_tab[sin_idx];
  end else begin : g_sin0
    assign w_im = '0;
  end

endmodule

// File: rtl/fourier_inv_srg.sv
// Inverse DFT engine: load N complex spectrum samples, compute x[n] = (1/N) sum X[k] e^{+j2pi kn/N}, read by address.
// Latency: done rises N*(N+1) cycles after the start edge; reads return on the next cycle.
// Backpressure: none; while busy every operation code is ignored, host polls busy/done.
//   clk, reset      : clock, synchronous active-high reset
//   operation, addr : 00 idle, 01 write X[addr], 10 start, 11 read x[addr]
//   x_re, x_im      : write data
//   y_re, y_im      : registered read data
//   busy, done      : compute in progress / all outputs stored (sticky)
module fourier_inv_srg
  import fourier_pkg::*;
#(
  parameter int N    = 16,
  parameter int W    = 32,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          operation,
  input  logic [31:0]         addr,
  input  logic signed [W-1:0] x_re,
  input  logic signed [W-1:0] x_im,
  output logic signed [W-1:0] y_re,
  output logic signed [W-1:0] y_im,
  output logic                busy,
  output logic                done
);

  localparam int LG = $clog2(N);
  localparam int AW = W + LG + 2;

  state_e state_q, state_d;
  op_e    op;

  logic [LG-1:0]       i_q, j_q;
  logic signed [AW-1:0] acc_re, acc_im;

  logic signed [W-1:0] xr_mem [N];
  logic signed [W-1:0] xi_mem [N];
  logic signed [W-1:0] or_mem [N];
  logic signed [W-1:0] oi_mem [N];

  logic [LG-1:0]       a_idx;
  logic                a_ok;

  logic [LG-1:0]       tw_idx;
  logic signed [W-1:0] w_re, w_im;

  logic signed [2*W-1:0] xr_j, xi_j, wr_e, wi_e;
  logic signed [2*W-1:0] term_re, term_im;
  logic signed [AW-1:0]  sh_re, sh_im;

  assign op    = op_e'(operation);
  assign a_idx = addr[LG-1:0];
  assign a_ok  = addr < 32'(N);

  // Product width LG truncates i*j, which is exactly the mod-N reduction.
  assign tw_idx = i_q * j_q;

  twiddle_rom #(.N(N), .W(W), .FRAC(FRAC)) u_rom (
    .idx  (tw_idx),
    .w_re (w_re),
    .w_im (w_im)
  );

  // Sign-extend operands to 2W so the products are exact before the FRAC shift.
  assign xr_j    = xr_mem[j_q];
  assign xi_j    = xi_mem[j_q];
  assign wr_e    = w_re;
  assign wi_e    = w_im;
  assign term_re = (xr_j * wr_e - xi_j * wi_e) >>> FRAC;
  assign term_im = (xr_j * wi_e + xi_j * wr_e) >>> FRAC;

  // Divide by N on the way out.
  assign sh_re = acc_re >>> LG;
  assign sh_im = acc_im >>> LG;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (op == OP_START) state_d = ST_MAC;
      ST_MAC:   if (j_q == LG'(N - 1)) state_d = ST_STORE;
      ST_STORE: state_d = (i_q == LG'(N - 1)) ? ST_IDLE : ST_MAC;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_q    <= '0;
      j_q    <= '0;
      acc_re <= '0;
      acc_im <= '0;
      y_re   <= '0;
      y_im   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        xr_mem[k] <= '0;
        xi_mem[k] <= '0;
        or_mem[k] <= '0;
        oi_mem[k] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          case (op)
            OP_WR: if (a_ok) begin
              xr_mem[a_idx] <= x_re;
              xi_mem[a_idx] <= x_im;
              done          <= 1'b0;
            end
            OP_START: begin
              i_q    <= '0;
              j_q    <= '0;
              acc_re <= '0;
              acc_im <= '0;
              busy   <= 1'b1;
              done   <= 1'b0;
            end
            OP_RD: begin
              y_re <= a_ok ? or_mem[a_idx] : '0;
              y_im <= a_ok ? oi_mem[a_idx] : '0;
            end
            default: ;
          endcase
        end
        ST_MAC: begin
          acc_re <= acc_re + AW'(term_re);
          acc_im <= acc_im + AW'(term_im);
          j_q    <= j_q + LG'(1);
        end
        ST_STORE: begin
          or_mem[i_q] <= W'(sat(128'(sh_re), W));
          oi_mem[i_q] <= W'(sat(128'(sh_im), W));
          acc_re      <= '0;
          acc_im      <= '0;
          j_q         <= '0;
          if (i_q == LG'(N - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            i_q <= i_q + LG'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fourier_inv_srg.sv
// Directed bench for the inverse DFT core at N=4, Q16 fixed point (1.0 = 0x0001_0000).
// Latency: checks done exactly 20 cycles after start.
// Backpressure: checks that operations are ignored while busy.
module tb_fourier_inv_srg;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int ONE = 32'h0001_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         operation;
  logic [31:0]        addr;
  logic signed [W-1:0] x_re, x_im;
  logic signed [W-1:0] y_re, y_im;
  logic               busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  fourier_inv_srg #(.N(N), .W(W), .FRAC(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .operation (operation),
    .addr      (addr),
    .x_re      (x_re),
    .x_im      (x_im),
    .y_re      (y_re),
    .y_im      (y_im),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
  endtask

  task automatic wr(input int a, input int re, input int im);
    @(negedge clk);
    operation = 2'b01; addr = 32'(a); x_re = re; x_im = im;
    @(negedge clk);
    operation = 2'b00;
  endtask

  task automatic rd(input int a, output int re, output int im);
    @(negedge clk);
    operation = 2'b11; addr = 32'(a);
    @(negedge clk);
    operation = 2'b00;
    re = y_re; im = y_im;
  endtask

  task automatic rd_chk(input string tag, input int a, input int ere, input int eim);
    int re, im;
    rd(a, re, im);
    check({tag, "_re"}, re, ere);
    check({tag, "_im"}, im, eim);
  endtask

  // Issues start, checks busy after the start edge, then waits for done and checks its timing.
  task automatic run(input string tag, input bit check_timing);
    int cyc;
    @(negedge clk);
    operation = 2'b10;
    @(negedge clk);
    operation = 2'b00;
    if (check_timing) check({tag, "_busy_rise"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, done, 1);
    if (check_timing) begin
      check({tag, "_done_cycles"}, cyc, 20);
      check({tag, "_busy_fall"}, busy, 0);
    end
  endtask

  task automatic clear_x();
    for (int k = 0; k < N; k++) wr(k, 0, 0);
  endtask

  int re, im;
  int rt_re [N];
  int rt_im [N];

  initial begin
    reset = 1'b1; operation = 2'b00; addr = '0; x_re = '0; x_im = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_y_re", y_re, 0);
    check("rst_y_im", y_im, 0);

    // DC bin only: every output sample is 1.0
    wr(0, 4 * ONE, 0);
    run("t1", 1'b1);
    for (int n = 0; n < N; n++) rd_chk($sformatf("t1_x%0d", n), n, ONE, 0);

    // Bin 1 only: x[n] = e^{+j pi n/2}
    clear_x();
    check("wr_clears_done", done, 0);
    wr(1, 4 * ONE, 0);
    run("t2", 1'b0);
    rd_chk("t2_x0", 0, ONE, 0);
    rd_chk("t2_x1", 1, 0, ONE);
    rd_chk("t2_x2", 2, -ONE, 0);
    rd_chk("t2_x3", 3, 0, -ONE);

    // Operations while busy are ignored; y holds the last read (x[3] above)
    @(negedge clk);
    operation = 2'b10;
    @(negedge clk);
    operation = 2'b01; addr = 32'd2; x_re = 8 * ONE; x_im = 3 * ONE;
    repeat (2) @(negedge clk);
    operation = 2'b11; addr = 32'd0;
    repeat (2) @(negedge clk);
    operation = 2'b10;
    @(negedge clk);
    operation = 2'b00;
    check("busy_y_re_hold", y_re, 0);
    check("busy_y_im_hold", y_im, -ONE);
    for (int c = 0; c < 200 && !done; c++) @(negedge clk);
    check("busy_done", done, 1);
    rd_chk("busy_x0", 0, ONE, 0);
    rd_chk("busy_x2", 2, -ONE, 0);
    rd_chk("oob_rd", 9, 0, 0);

    // Reset in the middle of a compute
    @(negedge clk);
    operation = 2'b10;
    @(negedge clk);
    operation = 2'b00;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    for (int n = 0; n < N; n++) rd_chk($sformatf("mid_rst_x%0d", n), n, 0, 0);

    // Round trip: forward DFT of ramp 0..3 is {6, -2+2j, -2, -2-2j}
    wr(0, 6 * ONE, 0);
    wr(1, -2 * ONE, 2 * ONE);
    wr(2, -2 * ONE, 0);
    wr(3, -2 * ONE, -2 * ONE);
    run("rt", 1'b1);
    for (int n = 0; n < N; n++) begin
      rd(n, re, im);
      rt_re[n] = re - n * ONE;
      rt_im[n] = im;
      check($sformatf("rt_x%0d_re_tol", n), (rt_re[n] >= -2 && rt_re[n] <= 2) ? 1 : 0, 1);
      check($sformatf("rt_x%0d_im_tol", n), (rt_im[n] >= -2 && rt_im[n] <= 2) ? 1 : 0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
